// File: rtl/alu_pkg.sv
// Shared definitions for the ALU request scheduler: opcodes, FSM encoding and
// default sizes.
package alu_pkg;

  localparam int DEF_WIDTH = 4;

  // Wait counter is wide enough for ALU_LAT-1 with ALU_LAT up to 7.
  localparam int CNT_W = 3;

  // Opcodes are forwarded to the ALU untouched; the scheduler never decodes them.
  localparam logic [2:0] ADD = 3'd0;
  localparam logic [2:0] SUB = 3'd1;
  localparam logic [2:0] AND = 3'd2;
  localparam logic [2:0] OR  = 3'd3;
  localparam logic [2:0] XOR = 3'd4;
  localparam logic [2:0] NOT = 3'd5;
  localparam logic [2:0] SHL = 3'd6;
  localparam logic [2:0] SHR = 3'd7;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

endpackage

// File: rtl/alu_sched_rr_pick.sv
// Combinational round-robin picker: the first requester strictly after i_last
// wins, wrapping past NREQ-1 back to 0.
module rr_pick #(
  parameter int NREQ = 4,
  parameter int IW   = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] i_req,
  input  logic [IW-1:0]   i_last,
  output logic [NREQ-1:0] o_grant,
  output logic [IW-1:0]   o_idx,
  output logic            o_any
);

  // Two passes: indices above i_last first, then the wrapped lower part.
  always_comb begin
    // NOTE: every output gets a default before the search so no path can infer a latch.
    o_grant = '0;
    o_idx   = '0;
    o_any   = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (!o_any && i_req[i] && (i > int'(i_last))) begin
        o_grant[i] = 1'b1;
        o_idx      = i[IW-1:0];
        o_any      = 1'b1;
      end
    end
    for (int i = 0; i < NREQ; i++) begin
      if (!o_any && i_req[i]) begin
        o_grant[i] = 1'b1;
        o_idx      = i[IW-1:0];
        o_any      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/alu_sched.sv
// Single-outstanding scheduler sharing one fixed-latency ALU between NREQ
// requesters, with round-robin arbitration and a valid/ready response channel.
module alu_sched
  import alu_pkg::*;
#(
  parameter int NREQ    = 4,
  parameter int WIDTH   = DEF_WIDTH,
  parameter int ALU_LAT = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NREQ-1:0]          req_valid,
  output logic [NREQ-1:0]          req_ready,
  input  logic [NREQ*3-1:0]        req_op,
  input  logic [NREQ*WIDTH-1:0]    req_a,
  input  logic [NREQ*WIDTH-1:0]    req_b,
  output logic                     alu_start,
  output logic [2:0]               alu_op,
  output logic [WIDTH-1:0]         alu_a,
  output logic [WIDTH-1:0]         alu_b,
  input  logic [WIDTH-1:0]         alu_result,
  input  logic                     alu_carry,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [$clog2(NREQ)-1:0]  rsp_id,
  output logic [WIDTH-1:0]         rsp_data,
  output logic                     rsp_carry,
  output logic                     busy
);

  localparam int IW = $clog2(NREQ);

  state_t              r_state;
  logic [IW-1:0]       r_last;
  logic [CNT_W-1:0]    r_cnt;
  logic                r_alu_start;
  logic [2:0]          r_alu_op;
  logic [WIDTH-1:0]    r_alu_a;
  logic [WIDTH-1:0]    r_alu_b;
  logic                r_rsp_valid;
  logic [IW-1:0]       r_rsp_id;
  logic [WIDTH-1:0]    r_rsp_data;
  logic                r_rsp_carry;

  logic [NREQ-1:0]     w_grant;
  logic [IW-1:0]       w_idx;
  logic                w_any;
  logic                w_idle;
  logic [2:0]          w_op;
  logic [WIDTH-1:0]    w_a;
  logic [WIDTH-1:0]    w_b;

  rr_pick #(
    .NREQ (NREQ),
    .IW   (IW)
  ) u_rr_pick (
    .i_req   (req_valid),
    .i_last  (r_last),
    .o_grant (w_grant),
    .o_idx   (w_idx),
    .o_any   (w_any)
  );

  // Grants are only offered from IDLE and never while reset is held.
  assign w_idle    = (r_state == IDLE) && rst_n;
  assign req_ready = w_idle ? w_grant : '0;

  // Select the granted requester's opcode and operands (grant is one-hot).
  always_comb begin
    w_op = '0;
    w_a  = '0;
    w_b  = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (w_grant[i]) begin
        w_op = req_op[3*i +: 3];
        w_a  = req_a[WIDTH*i +: WIDTH];
        w_b  = req_b[WIDTH*i +: WIDTH];
      end
    end
  end

  // Scheduler FSM with registered ALU issue and response outputs.
  always_ff @(posedge clk) begin
    // NOTE: all state uses non-blocking assignments so every register samples pre-edge values.
    if (!rst_n) begin
      r_state     <= IDLE;
      r_last      <= IW'(NREQ - 1);
      r_cnt       <= '0;
      r_alu_start <= 1'b0;
      r_alu_op    <= '0;
      r_alu_a     <= '0;
      r_alu_b     <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_id    <= '0;
      r_rsp_data  <= '0;
      r_rsp_carry <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_any) begin
            r_alu_op    <= w_op;
            r_alu_a     <= w_a;
            r_alu_b     <= w_b;
            r_rsp_id    <= w_idx;
            r_last      <= w_idx;
            r_alu_start <= 1'b1;
            r_state     <= ISSUE;
          end
        end
        ISSUE: begin
          r_alu_start <= 1'b0;
          r_cnt       <= CNT_W'(ALU_LAT - 1);
          r_state     <= WAIT;
        end
        WAIT: begin
          if (r_cnt == '0) begin
            r_rsp_data  <= alu_result;
            r_rsp_carry <= alu_carry;
            r_rsp_valid <= 1'b1;
            r_state     <= RESP;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_state     <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign alu_start = r_alu_start;
  assign alu_op    = r_alu_op;
  assign alu_a     = r_alu_a;
  assign alu_b     = r_alu_b;
  assign rsp_valid = r_rsp_valid;
  assign rsp_id    = r_rsp_id;
  assign rsp_data  = r_rsp_data;
  assign rsp_carry = r_rsp_carry;
  assign busy      = (r_state != IDLE);

endmodule

// File: tb/tb_alu_sched.sv
// Bench for alu_sched: behavioural fixed-latency ALU, table of single
// transactions, then fairness, backpressure and mid-operation reset sequences.
module tb_alu_sched;
  import alu_pkg::*;

  localparam int NREQ    = 4;
  localparam int WIDTH   = 4;
  localparam int ALU_LAT = 2;
  localparam int IW      = $clog2(NREQ);

  logic                    clk = 1'b0;
  logic                    rst_n;
  logic [NREQ-1:0]         req_valid;
  logic [NREQ-1:0]         req_ready;
  logic [NREQ*3-1:0]       req_op;
  logic [NREQ*WIDTH-1:0]   req_a;
  logic [NREQ*WIDTH-1:0]   req_b;
  logic                    alu_start;
  logic [2:0]              alu_op;
  logic [WIDTH-1:0]        alu_a;
  logic [WIDTH-1:0]        alu_b;
  logic [WIDTH-1:0]        alu_result;
  logic                    alu_carry;
  logic                    rsp_valid;
  logic                    rsp_ready;
  logic [IW-1:0]           rsp_id;
  logic [WIDTH-1:0]        rsp_data;
  logic                    rsp_carry;
  logic                    busy;

  alu_sched #(
    .NREQ    (NREQ),
    .WIDTH   (WIDTH),
    .ALU_LAT (ALU_LAT)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_op     (req_op),
    .req_a      (req_a),
    .req_b      (req_b),
    .alu_start  (alu_start),
    .alu_op     (alu_op),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_result (alu_result),
    .alu_carry  (alu_carry),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_id     (rsp_id),
    .rsp_data   (rsp_data),
    .rsp_carry  (rsp_carry),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;
  int cyc     = 0;

  typedef struct packed {
    logic [IW-1:0]    id;
    logic [WIDTH-1:0] data;
    logic             carry;
  } exp_t;

  exp_t sb_q[$];

  typedef struct {
    logic [NREQ-1:0]  valid;
    int               id;
    logic [2:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] data;
    logic             carry;
  } vec_t;

  vec_t tbl[10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  // Behavioural ALU: carry is the 5th result bit, borrow for SUB, shifted-out bit for shifts.
  function automatic logic [WIDTH:0] alu_f(input logic [2:0] op, input logic [WIDTH-1:0] a,
                                           input logic [WIDTH-1:0] b);
    case (op)
      ADD:     return {1'b0, a} + {1'b0, b};
      SUB:     return {1'b0, a} - {1'b0, b};
      AND:     return {1'b0, a & b};
      OR:      return {1'b0, a | b};
      XOR:     return {1'b0, a ^ b};
      NOT:     return {1'b0, ~a};
      SHL:     return {a[WIDTH-1], a[WIDTH-2:0], 1'b0};
      default: return {a[0], 1'b0, a[WIDTH-1:1]};
    endcase
  endfunction

  // ALU latency model: result is only correct in the cycle ALU_LAT after the start cycle.
  logic [3:0]       tcnt = '0;
  logic [WIDTH:0]   w_f;
  always @(posedge clk) begin
    if (!rst_n)          tcnt <= '0;
    else if (alu_start)  tcnt <= 4'(ALU_LAT);
    else if (tcnt != 0)  tcnt <= tcnt - 4'd1;
  end

  always_comb begin
    w_f        = alu_f(alu_op, alu_a, alu_b);
    alu_result = (tcnt == 4'd1) ? w_f[WIDTH-1:0] : ~w_f[WIDTH-1:0];
    alu_carry  = (tcnt == 4'd1) ? w_f[WIDTH]     : ~w_f[WIDTH];
  end

  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard: every completed response handshake is matched against the oldest expectation.
  always @(negedge clk) begin
    if (rst_n && rsp_valid && rsp_ready) begin
      check("sb_nonempty", 32'(sb_q.size() != 0), 1);
      if (sb_q.size() != 0) begin
        exp_t e;
        e = sb_q.pop_front();
        check("rsp_id",    rsp_id,    e.id);
        check("rsp_data",  rsp_data,  e.data);
        check("rsp_carry", rsp_carry, e.carry);
      end
    end
  end

  // Granted requester gets the real operands; every other requester carries inverted decoys.
  task automatic drive(input logic [NREQ-1:0] v, input int id, input logic [2:0] op,
                       input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    req_valid = v;
    for (int i = 0; i < NREQ; i++) begin
      if (i == id) begin
        req_op[3*i +: 3]         = op;
        req_a[WIDTH*i +: WIDTH]  = a;
        req_b[WIDTH*i +: WIDTH]  = b;
      end else begin
        req_op[3*i +: 3]         = ~op;
        req_a[WIDTH*i +: WIDTH]  = ~a;
        req_b[WIDTH*i +: WIDTH]  = ~b;
      end
    end
  endtask

  function automatic logic [NREQ-1:0] onehot(input int id);
    logic [NREQ-1:0] g;
    g     = '0;
    g[id] = 1'b1;
    return g;
  endfunction

  task automatic push(input int id, input logic [WIDTH-1:0] d, input logic c);
    exp_t e;
    e.id    = IW'(id);
    e.data  = d;
    e.carry = c;
    sb_q.push_back(e);
  endtask

  task automatic wait_rsp(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!rsp_valid && n < 30);
    check("rsp_seen", rsp_valid, 1);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb_q.size() != 0 && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("drain", sb_q.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int n;
    int prev;
    bit seen;

    tbl[0] = '{4'b0001, 0, ADD, 4'h7, 4'h5, 4'hC, 1'b0};
    tbl[1] = '{4'b0110, 1, SUB, 4'h3, 4'h5, 4'hE, 1'b1};
    tbl[2] = '{4'b1111, 2, AND, 4'hC, 4'hA, 4'h8, 1'b0};
    tbl[3] = '{4'b0011, 0, OR,  4'h5, 4'hA, 4'hF, 1'b0};
    tbl[4] = '{4'b1000, 3, XOR, 4'hF, 4'h3, 4'hC, 1'b0};
    tbl[5] = '{4'b0101, 0, NOT, 4'h6, 4'h0, 4'h9, 1'b0};
    tbl[6] = '{4'b0101, 2, SHL, 4'h9, 4'h0, 4'h2, 1'b1};
    tbl[7] = '{4'b0010, 1, SHR, 4'hB, 4'h0, 4'h5, 1'b1};
    tbl[8] = '{4'b1111, 2, ADD, 4'hF, 4'h1, 4'h0, 1'b1};
    tbl[9] = '{4'b1000, 3, ADD, 4'h9, 4'h8, 4'h1, 1'b1};

    // Reset with all requesters asserting: everything must read zero.
    rst_n     = 1'b0;
    rsp_ready = 1'b1;
    drive(4'b1111, 0, ADD, 4'h1, 4'h1);
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_ready",     req_ready, 0);
    check("rst_busy",      busy,      0);
    check("rst_start",     alu_start, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_alu_op",    alu_op,    0);
    check("rst_alu_a",     alu_a,     0);
    check("rst_rsp_data",  rsp_data,  0);
    @(posedge clk); #1;
    rst_n     = 1'b1;
    req_valid = '0;

    // Table of single transactions: grant, issue timing, operands and latency.
    for (int k = 0; k < 10; k++) begin
      @(posedge clk); #1;
      drive(tbl[k].valid, tbl[k].id, tbl[k].op, tbl[k].a, tbl[k].b);
      @(negedge clk);
      check($sformatf("grant[%0d]", k), req_ready, onehot(tbl[k].id));
      push(tbl[k].id, tbl[k].data, tbl[k].carry);
      @(posedge clk); #1;
      req_valid = '0;
      @(negedge clk);
      check($sformatf("start[%0d]", k), alu_start, 1);
      check($sformatf("busy[%0d]", k),  busy,      1);
      check($sformatf("ready0[%0d]", k), req_ready, 0);
      check($sformatf("alu_op[%0d]", k), alu_op,   tbl[k].op);
      check($sformatf("alu_a[%0d]", k),  alu_a,    tbl[k].a);
      check($sformatf("alu_b[%0d]", k),  alu_b,    tbl[k].b);
      wait_rsp(n);
      check($sformatf("rsp_lat[%0d]", k), n, ALU_LAT + 1);
    end

    // Fairness: all requesters held valid, grants rotate 0,1,2,3,0 at the minimum interval.
    @(posedge clk); #1;
    req_valid = '1;
    for (int i = 0; i < NREQ; i++) begin
      req_op[3*i +: 3]        = ADD;
      req_a[WIDTH*i +: WIDTH] = WIDTH'(i);
      req_b[WIDTH*i +: WIDTH] = WIDTH'(i + 1);
    end
    prev = 0;
    for (int k = 0; k < 5; k++) begin
      n = 0;
      do begin
        @(negedge clk);
        n++;
      end while (req_ready == '0 && n < 20);
      check($sformatf("fair_grant[%0d]", k), req_ready, onehot(k % NREQ));
      if (k > 0) check($sformatf("fair_gap[%0d]", k), cyc - prev, ALU_LAT + 3);
      prev = cyc;
      push(k % NREQ, WIDTH'(2 * (k % NREQ) + 1), 1'b0);
    end
    @(posedge clk); #1;
    req_valid = '0;
    drain();

    // Backpressure: response held for 6 stalled cycles while requester 1 waits.
    @(posedge clk); #1;
    drive(4'b0100, 2, ADD, 4'h2, 4'h3);
    rsp_ready = 1'b0;
    @(negedge clk);
    check("bp_grant", req_ready, 4'b0100);
    push(2, 4'h5, 1'b0);
    @(posedge clk); #1;
    drive(4'b0010, 1, ADD, 4'h1, 4'h1);
    wait_rsp(n);
    for (int j = 0; j < 6; j++) begin
      check($sformatf("bp_valid[%0d]", j), rsp_valid, 1);
      check($sformatf("bp_data[%0d]", j),  rsp_data,  4'h5);
      check($sformatf("bp_id[%0d]", j),    rsp_id,    2);
      check($sformatf("bp_ready[%0d]", j), req_ready, 0);
      @(negedge clk);
    end
    @(posedge clk); #1;
    rsp_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("bp_accept", req_ready, 4'b0010);
    push(1, 4'h2, 1'b0);
    @(posedge clk); #1;
    req_valid = '0;
    drain();

    // Reset during WAIT: op is discarded and the pointer restarts at requester 0.
    @(posedge clk); #1;
    drive(4'b0100, 2, XOR, 4'h5, 4'h5);
    @(negedge clk);
    check("mr_grant", req_ready, 4'b0100);
    @(posedge clk); #1;
    req_valid = '0;
    @(posedge clk); #1;
    check("mr_in_wait", busy, 1);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("mr_busy",      busy,      0);
    check("mr_rsp_valid", rsp_valid, 0);
    check("mr_start",     alu_start, 0);
    check("mr_alu_a",     alu_a,     0);
    seen = 1'b0;
    repeat (8) begin
      @(negedge clk);
      seen = seen | rsp_valid;
    end
    check("mr_no_rsp", seen, 0);
    @(posedge clk); #1;
    drive(4'b1111, 0, SUB, 4'h1, 4'h2);
    @(negedge clk);
    check("mr_ptr", req_ready, 4'b0001);
    push(0, 4'hF, 1'b1);
    @(posedge clk); #1;
    req_valid = '0;
    drain();

    check("sb_empty_end", sb_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
